// File: rtl/uart_tx_slave.sv
// Console UART transmitter on the picorv32 native memory bus: a byte FIFO feeds
// an 8N1 serial engine with a runtime-programmable baud divisor.
module uart_tx_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        uart_txd,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Bus handshake: a selected request (mem_valid high in our window) is acked
  // by a registered one-cycle mem_ready pulse; mem_rdata is non-zero only in
  // that pulse. The cycle after an ack never acks, and a DATA push into a full
  // FIFO is held off (no ack) until the same edge that pops a byte.
  logic                sel, is_write, push_req, accept, push, pop;
  logic [1:0]          reg_off;
  logic [31:0]         rdata_d;
  logic [15:0]         div_q;

  logic [7:0]          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                fifo_full, fifo_empty;
  logic [7:0]          fifo_rd;

  tx_state_t           state_q, state_d;
  logic [7:0]          shift_q, shift_d;
  logic [15:0]         period_q, period_d;
  logic [15:0]         baud_q, baud_d;
  logic [15:0]         bit_q, bit_d;
  logic                txd_q, txd_d;
  logic [15:0]         new_period;
  logic                bit_done, busy, load_frame;
  logic                unused_bits;

  assign sel        = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off    = mem_addr[3:2];
  assign is_write   = |mem_wstrb;
  assign push_req   = sel && is_write && (reg_off == 2'd0) && mem_wstrb[0];
  assign accept     = sel && !mem_ready && (!push_req || !fifo_full || pop);
  assign push       = accept && push_req;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign fifo_rd    = fifo_mem[rd_ptr];

  assign busy       = (state_q != IDLE);
  assign bit_done   = (baud_q == 16'd0);
  assign new_period = (div_q == 16'd0) ? 16'd1 : div_q;

  assign uart_txd    = txd_q;
  assign dbg_state   = state_q;
  assign unused_bits = ^{mem_wdata[31:16], mem_addr[1:0]};

  always_comb begin
    rdata_d = '0;
    if (!is_write) begin
      case (reg_off)
        2'd1:    rdata_d = {16'b0, 8'(count), 5'b0, busy, fifo_empty, fifo_full};
        2'd2:    rdata_d = {16'b0, div_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      div_q     <= DIV_RESET;
    end else begin
      mem_ready <= accept;
      mem_rdata <= accept ? rdata_d : '0;
      if (accept && reg_off == 2'd2) begin
        if (mem_wstrb[0]) div_q[7:0]  <= mem_wdata[7:0];
        if (mem_wstrb[1]) div_q[15:8] <= mem_wdata[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Each bit lasts period_q cycles: baud_q counts period_q-1 down to 0.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    period_d   = period_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    txd_d      = txd_q;
    load_frame = 1'b0;
    if (state_q != IDLE && !bit_done) baud_d = baud_q - 16'd1;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) load_frame = 1'b1;
      end
      START: if (bit_done) begin
        state_d = DATA;
        baud_d  = period_q - 16'd1;
        bit_d   = 16'd0;
        txd_d   = shift_q[0];
      end
      DATA: if (bit_done) begin
        baud_d = period_q - 16'd1;
        if (bit_q == 16'd7) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end else begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 16'd1;
          txd_d   = shift_q[1];
        end
      end
      STOP: if (bit_done) begin
        if (!fifo_empty) begin
          load_frame = 1'b1;
        end else begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Divisor is sampled only here, so a mid-frame DIV write waits for the next frame.
    if (load_frame) begin
      shift_d  = fifo_rd;
      period_d = new_period;
      baud_d   = new_period - 16'd1;
      bit_d    = 16'd0;
      state_d  = START;
      txd_d    = 1'b0;
    end
    pop = load_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      period_q <= 16'd1;
      baud_q   <= '0;
      bit_q    <= '0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      period_q <= period_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      txd_q    <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_slave.sv
// Bench for uart_tx_slave: bus driver tasks, an ack/rdata scoreboard and a
// serial-line monitor that checks every frame against an expected byte queue.
module tb_uart_tx_slave;

  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam int W = 24;  // {period[15:0], byte[7:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        uart_txd;
  logic [1:0]  unused_dbg_state;

  uart_tx_slave dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .uart_txd  (uart_txd),
    .dbg_state (unused_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  exp_q[$];
  logic [31:0]   rd_q[$];
  string         name_q[$];
  int            start_q[$];
  logic [15:0]   div_model = 16'd868;

  function automatic logic frame_level(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic logic [15:0] period_of(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  // serial monitor
  logic         in_frame = 1'b0;
  logic         junk = 1'b0;
  logic [W-1:0] cur;
  int           pos = 0;
  int           per;
  logic         frame_ok;
  int           bad_pos;
  logic         bad_lvl, want_lvl;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      junk     = 1'b0;
      exp_q.delete();
    end else begin
      if (junk && uart_txd === 1'b1) junk = 1'b0;
      if (!in_frame && !junk && uart_txd !== 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL line_idle: line=%b at cycle %0d with no byte pending, want 1", uart_txd, cyc);
          junk = 1'b1;
        end else begin
          cur = exp_q.pop_front();
          in_frame = 1'b1; pos = 0; frame_ok = 1'b1;
          start_q.push_back(cyc);
        end
      end
      if (in_frame) begin
        per = int'(cur[23:8]);
        if (uart_txd !== frame_level(cur[7:0], pos / per) && frame_ok) begin
          frame_ok = 1'b0; bad_pos = pos; bad_lvl = uart_txd;
          want_lvl = frame_level(cur[7:0], pos / per);
        end
        pos++;
        if (pos == 10 * per) begin
          total++;
          in_frame = 1'b0;
          if (!frame_ok) begin
            bad++;
            $display("FAIL frame_%02h: frame cycle %0d line=%b, want %b (period %0d)",
                     cur[7:0], bad_pos, bad_lvl, want_lvl, per);
          end
        end
      end
    end
  end

  // bus ack / read-data monitor
  logic [31:0] rd_exp;
  string       rd_name;
  always @(negedge clk) begin
    if (!rst && mem_ready === 1'b1) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL extra_ack: mem_ready=1 at cycle %0d, want 0", cyc);
      end else begin
        rd_exp  = rd_q.pop_front();
        rd_name = name_q.pop_front();
        if (mem_rdata !== rd_exp) begin
          bad++;
          $display("FAIL %s: mem_rdata=%h, want %h", rd_name, mem_rdata, rd_exp);
        end
      end
    end
  end

  // driver tasks
  task automatic bus_xfer(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic expect_ack, input logic [31:0] exp_rdata,
                          input int budget, input int hold, output int waited);
    logic acked;
    if (expect_ack) begin
      rd_q.push_back(exp_rdata);
      name_q.push_back(name);
    end
    @(negedge clk);
    mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_valid = 1'b1;
    acked = 1'b0; waited = 0;
    while (!acked && waited < budget) begin
      @(negedge clk);
      waited++;
      if (mem_ready === 1'b1) acked = 1'b1;
    end
    repeat (hold) @(negedge clk);
    mem_valid = 1'b0; mem_wstrb = '0;
    total++;
    if (expect_ack && !acked) begin
      bad++;
      $display("FAIL %s_ack: no mem_ready in %0d cycles, want ack", name, budget);
      void'(rd_q.pop_back());
      void'(name_q.pop_back());
    end else if (!expect_ack && acked) begin
      bad++;
      $display("FAIL %s_noack: mem_ready=1 after %0d cycles, want no ack", name, waited);
    end
  endtask

  task automatic wr_data(input logic [7:0] b, input int hold, input int budget, output int waited);
    logic [31:0] w;
    w = $urandom();
    w[7:0] = b;
    exp_q.push_back({period_of(div_model), b});
    bus_xfer("data_wr", BASE, w, 4'b0001 | 4'($urandom_range(0, 7) << 1), 1'b1, 32'h0, budget, hold, waited);
  endtask

  task automatic wr_div(input logic [31:0] w, input logic [3:0] strb);
    int waited;
    if (strb[0]) div_model[7:0]  = w[7:0];
    if (strb[1]) div_model[15:8] = w[15:8];
    bus_xfer("div_wr", BASE + 32'h8, w, strb, 1'b1, 32'h0, 50, 0, waited);
  endtask

  task automatic rd_reg(input string name, input logic [31:0] addr, input logic [31:0] exp_v);
    int waited;
    bus_xfer(name, addr, $urandom(), 4'b0000, 1'b1, exp_v, 50, 0, waited);
  endtask

  task automatic send(input logic [7:0] b);
    int waited;
    wr_data(b, 0, 50, waited);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || in_frame) begin
      bad++;
      $display("FAIL %s_drain: %0d frames still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_gaps(input string name, input int n, input int gap);
    total++;
    if (start_q.size() != n) begin
      bad++;
      $display("FAIL %s_frames: saw %0d frame starts, want %0d", name, start_q.size(), n);
    end else begin
      for (int i = 1; i < n; i++) begin
        if (start_q[i] - start_q[i-1] != gap) begin
          bad++;
          $display("FAIL %s_gap: frame %0d started %0d cycles after previous, want %0d",
                   name, i, start_q[i] - start_q[i-1], gap);
          break;
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   waited;
    logic idle_ok;
    logic [7:0]  b;
    logic [31:0] w;
    logic [3:0]  strb;

    // reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || mem_ready !== 1'b0) idle_ok = 1'b0;
    end
    total++;
    if (!idle_ok) begin
      bad++;
      $display("FAIL reset_idle: txd=%b ready=%b, want txd=1 ready=0", uart_txd, mem_ready);
    end
    rd_reg("status_reset", BASE + 32'h4, 32'h0000_0002);
    rd_reg("div_reset", BASE + 32'h8, 32'h0000_0364);

    // single frame at DIV=4
    wr_div(32'h0000_0004, 4'b0011);
    rd_reg("div_rd4", BASE + 32'h8, 32'h0000_0004);
    send(8'h55);
    rd_reg("status_busy", BASE + 32'h4, 32'h0000_0006);
    rd_reg("data_rd", BASE, 32'h0);
    wait_idle("single");

    // back-to-back frames
    start_q.delete();
    send(8'h41); send(8'h42); send(8'h43);
    wait_idle("b2b");
    check_gaps("b2b", 3, 40);
    rd_reg("status_after_b2b", BASE + 32'h4, 32'h0000_0002);

    // held mem_valid past the ack must not push twice
    wr_data(8'h5A, 1, 50, waited);
    wait_idle("hold");

    // DIV change while a frame is in flight applies to the next frame
    start_q.delete();
    send(8'hA5);
    wr_div(32'h0000_0006, 4'b0011);
    send(8'h3C);
    wait_idle("div_mid");
    check_gaps("div_mid", 2, 40);

    // fill the FIFO, then a write that must stall until a slot frees
    wr_div(32'h0000_0014, 4'b0011);
    for (int i = 0; i < 17; i++) send(8'($urandom()));
    rd_reg("status_full", BASE + 32'h4, 32'h0000_1005);
    wr_data(8'hE7, 0, 1000, waited);
    total++;
    if (waited < 100) begin
      bad++;
      $display("FAIL full_stall: ack after %0d cycles, want >= 100", waited);
    end
    wait_idle("fill");
    rd_reg("status_drained", BASE + 32'h4, 32'h0000_0002);

    // randomized divisors and bursts
    for (int r = 0; r < 8; r++) begin
      w = {16'($urandom()), 8'h00, 8'($urandom_range(0, 6))};
      strb = ($urandom_range(0, 1) == 0) ? 4'b0001 : 4'b0011;
      wr_div(w, strb);
      rd_reg("div_rand", BASE + 32'h8, {16'h0, div_model});
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        b = 8'($urandom());
        send(b);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      bus_xfer("data_nostrb", BASE, $urandom(), 4'b0010, 1'b1, 32'h0, 50, 0, waited);
      wait_idle("rand");
    end

    // address decode and reserved register
    bus_xfer("foreign_wr", 32'h8000_0000, 32'h0000_0077, 4'b0001, 1'b0, 32'h0, 10, 0, waited);
    bus_xfer("foreign_rd", 32'h8000_0004, 32'h0, 4'b0000, 1'b0, 32'h0, 10, 0, waited);
    bus_xfer("near_miss", BASE + 32'h10, 32'h0000_0066, 4'b0001, 1'b0, 32'h0, 10, 0, waited);
    bus_xfer("rsvd_wr", BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0, 50, 0, waited);
    rd_reg("rsvd_rd", BASE + 32'hC, 32'h0);
    rd_reg("status_rsvd", BASE + 32'h4, 32'h0000_0002);
    rd_reg("div_rsvd", BASE + 32'h8, {16'h0, div_model});
    repeat (100) @(negedge clk);

    // reset in the middle of data bit 3, with a second byte still queued
    wr_div(32'h0000_0004, 4'b0011);
    send(8'h55);
    send(8'h66);
    waited = 0;
    while (!(in_frame && pos >= 17 && pos <= 19) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (waited >= 500) begin
      bad++;
      $display("FAIL rst_mid_reach: frame never reached data bit 3, want it within 500 cycles");
    end
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if (uart_txd !== 1'b1 || mem_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_line: txd=%b ready=%b, want txd=1 ready=0", uart_txd, mem_ready);
    end
    #1 rst = 1'b0;
    div_model = 16'd868;
    rd_reg("status_rst_mid", BASE + 32'h4, 32'h0000_0002);
    rd_reg("div_rst_mid", BASE + 32'h8, 32'h0000_0364);
    repeat (200) @(negedge clk);
    total++;
    if (rd_q.size() != 0) begin
      bad++;
      $display("FAIL ack_drain: %0d acks never seen, want 0", rd_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
